// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: two combinational read ports and one
// synchronous write port. x0 always reads as zero.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  writeEn;

    assign writeEn = regWrite && (writeReg != '0);

    // Reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[writeReg] <= writeData;
        end
    end

    // No write-to-read bypass: a pending write shows up only after the edge.
    // Index 0 is forced to zero, so x0 reads zero even before the first reset.
    assign readData1 = (readReg1 == '0) ? '0 : regs[readReg1];
    assign readData2 = (readReg2 == '0) ? '0 : regs[readReg2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, x0, enable timing,
// reset priority and dual-port reads, checked with immediate assertions.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int nAsserts = 0;
    int nFail    = 0;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        readReg1  = '0;
        readReg2  = '0;

        // Reset clears
        edge1();
        reset = 1'b0;
        readReg1 = 5'd0; readReg2 = 5'd2; #1;
        check("rst_x0", readData1, 32'd0);
        check("rst_x2", readData2, 32'd0);
        readReg1 = 5'd5; readReg2 = 5'd31; #1;
        check("rst_x5", readData1, 32'd0);
        check("rst_x31", readData2, 32'd0);

        // Basic write/read
        regWrite = 1'b1; writeReg = 5'd2; writeData = 32'd200;
        edge1();
        writeReg = 5'd5; writeData = 32'd10;
        edge1();
        regWrite = 1'b0;
        readReg1 = 5'd2; readReg2 = 5'd5; #1;
        check("wr_x2", readData1, 32'd200);
        check("wr_x5", readData2, 32'd10);

        // Reset is synchronous, then clears prior contents
        reset = 1'b1; #1;
        check("rst_not_async", readData1, 32'd200);
        edge1();
        reset = 1'b0; #1;
        check("rst2_x2", readData1, 32'd0);
        check("rst2_x5", readData2, 32'd0);

        // x0 immutability
        regWrite = 1'b1; writeReg = 5'd1; writeData = 32'h1234_5678;
        edge1();
        writeReg = 5'd0; writeData = 32'hDEAD_BEEF;
        edge1();
        regWrite = 1'b0;
        readReg1 = 5'd0; readReg2 = 5'd1; #1;
        check("x0_zero", readData1, 32'd0);
        check("x1_kept", readData2, 32'h1234_5678);

        // Write enable and no-bypass timing
        writeReg = 5'd7; writeData = 32'd55;
        edge1();
        readReg1 = 5'd7; #1;
        check("x7_no_we", readData1, 32'd0);
        regWrite = 1'b1; #1;
        check("x7_before_edge", readData1, 32'd0);
        edge1();
        regWrite = 1'b0;
        check("x7_after_edge", readData1, 32'd55);

        // Reset priority over a simultaneous write
        reset = 1'b1; regWrite = 1'b1; writeReg = 5'd3; writeData = 32'd99;
        edge1();
        reset = 1'b0; regWrite = 1'b0;
        readReg1 = 5'd3; readReg2 = 5'd7; #1;
        check("prio_x3", readData1, 32'd0);
        check("prio_x7", readData2, 32'd0);

        // Dual read of the same register
        regWrite = 1'b1; writeReg = 5'd31; writeData = 32'hFFFF_FFFF;
        edge1();
        regWrite = 1'b0;
        readReg1 = 5'd31; readReg2 = 5'd31; #1;
        check("dual_p1_x31", readData1, 32'hFFFF_FFFF);
        check("dual_p2_x31", readData2, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the multicycle RISC-V datapath.
- Two combinational read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Sits between the instruction-decode fields (rs1/rs2/rd) and the ALU operand latches.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- readReg1  input  ADDR_WIDTH  index for read port 1 (rs1).
- readReg2  input  ADDR_WIDTH  index for read port 2 (rs2).
- writeReg  input  ADDR_WIDTH  index for the write port (rd).
- writeData  input  DATA_WIDTH  data to write.
- regWrite  input  1  write enable, active-high.
- readData1  output  DATA_WIDTH  contents of register readReg1.
- readData2  output  DATA_WIDTH  contents of register readReg2.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Storage: NUM_REGS registers of DATA_WIDTH bits.
- Reset, on a rising clk edge with reset=1:
  - all registers are set to 0;
  - reset has priority over any write in the same cycle;
  - reset asserted mid-operation discards prior contents at that edge.
- Reset is not asynchronous: asserting reset between edges changes nothing until the next rising edge.
- Write, on a rising clk edge with reset=0 and regWrite=1:
  - register[writeReg] <= writeData;
  - if writeReg == 0, the write is ignored and x0 stays 0.
- regWrite=0: no register changes; writeReg and writeData are don't-care.
- Reads:
  - purely combinational, zero latency: readData1 = register[readReg1], readData2 = register[readReg2];
  - index 0 always reads 0.
- Both read ports are independent and may address the same register, including the register being written.
- No write-to-read bypass:
  - in the cycle a write is pending, reads of writeReg return the old value;
  - the new value appears immediately after the rising edge.
- Outputs after reset: readData1 = readData2 = 0 for every index until written.
- No X propagation from storage: every register is defined after the first reset edge.
- Pre-reset contents are unspecified. The bench must apply reset before checking.

Test Plan:
- Reset clears: hold reset=1 for one edge, release, read indices 0, 2, 5, 31 -> all read 0.
- Basic write/read:
  - write 200 to x2 and 10 to x5 on consecutive edges (regWrite=1), then regWrite=0;
  - set readReg1=2, readReg2=5 -> readData1=200, readData2=10.
- Reset after writes: with x2=200 and x5=10, assert reset for one edge -> readData1=0, readData2=0 for readReg1=2, readReg2=5.
- x0 immutability: write 0xDEADBEEF to x0 with regWrite=1 -> readData1=0 with readReg1=0. Also check x1 is unchanged.
- Write enable and timing:
  - with regWrite=0, drive writeReg=7, writeData=55 across an edge -> x7 still reads 0;
  - with regWrite=1, x7 reads the old value before the edge and 55 immediately after.
- Priority and dual read:
  - reset=1 and regWrite=1 (x3 <= 99) in the same edge -> x3 reads 0;
  - then write x31=0xFFFFFFFF and read it on both ports simultaneously -> both outputs read 0xFFFFFFFF.
